// File: rtl/ddr_responder.sv
// Memory-side DDR responder backed by a word array, with a host backdoor load port.
// Latency: reads return r_valid/r_data exactly ReadLatency cycles after the accept cycle; writes land at the accepting edge.
// Backpressure: waitrequest_n drops while load_en_i is high or MaxOutstanding reads are in flight (plus LFSR stalls if enabled).
//
// Ports:
//   clk_i, rst_ni                    clock, async active-low reset
//   ddr_address_i/_w_en_i/_w_data_i  front-side write command
//   ddr_r_en_i                       front-side read command
//   ddr_waitrequest_n_o              high = command accepted at the next rising edge
//   ddr_r_data_o/_r_valid_o          in-order read return; data holds while not valid
//   load_en_i/_addr_i/_data_i        backdoor array write, blocks the front side that cycle
//   error_o                          sticky range / r+w collision error
//   outstanding_o                    accepted reads not yet returned
//
// Optional: define DDR_RESPONDER_STALL_INJECT_EN to add pseudo-random LFSR stalls on waitrequest_n.

module ddr_responder #(
  parameter int MemWords       = 4096,
  parameter int ReadLatency    = 4,
  parameter int MaxOutstanding = 3,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [AddrWidth-1:0]                  ddr_address_i,
  input  logic                                  ddr_w_en_i,
  input  logic [DataWidth-1:0]                  ddr_w_data_i,
  input  logic                                  ddr_r_en_i,
  output logic                                  ddr_waitrequest_n_o,
  output logic [DataWidth-1:0]                  ddr_r_data_o,
  output logic                                  ddr_r_valid_o,
  input  logic                                  load_en_i,
  input  logic [$clog2(MemWords)-1:0]           load_addr_i,
  input  logic [DataWidth-1:0]                  load_data_i,
  output logic                                  error_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o
);

  localparam int IdxW = $clog2(MemWords);
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

  logic [DataWidth-1:0]   mem [MemWords];

  // run_q keeps waitrequest_n low until the first edge after reset release.
  logic                   run_q;
  logic [CntW-1:0]        cnt_q;
  logic                   err_q;
  logic [ReadLatency-1:0] vld_q;
  logic [DataWidth-1:0]   dat_q [ReadLatency];

  logic                   stall_inj;
  logic                   cmd_acc;
  logic                   wr_acc;
  logic                   rd_acc;
  logic                   in_range;
  logic [IdxW-1:0]        idx;
  logic [DataWidth-1:0]   rd_word;

`ifdef DDR_RESPONDER_STALL_INJECT_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign stall_inj = (lfsr_q[1:0] == 2'b00);
`else
  assign stall_inj = 1'b0;
`endif

  // Uses the registered count: a return in the same cycle does not reopen acceptance.
  assign ddr_waitrequest_n_o = run_q && !load_en_i && (cnt_q < MaxCnt) && !stall_inj;

  assign cmd_acc  = ddr_waitrequest_n_o && (ddr_r_en_i || ddr_w_en_i);
  assign wr_acc   = cmd_acc && ddr_w_en_i;
  // A read paired with a write is ignored; the write wins.
  assign rd_acc   = cmd_acc && ddr_r_en_i && !ddr_w_en_i;
  assign in_range = ~|ddr_address_i[AddrWidth-1:IdxW];
  assign idx      = ddr_address_i[IdxW-1:0];
  assign rd_word  = in_range ? mem[idx] : '0;

  // Array is never reset. Backdoor and front-side writes are exclusive because
  // load_en_i closes acceptance in the same cycle.
  always_ff @(posedge clk_i) begin
    if (load_en_i) begin
      mem[load_addr_i] <= load_data_i;
    end else if (wr_acc && in_range) begin
      mem[idx] <= ddr_w_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      err_q <= 1'b0;
      vld_q <= '0;
      for (int i = 0; i < ReadLatency; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      run_q <= 1'b1;
      cnt_q <= cnt_q + CntW'(rd_acc) - CntW'(vld_q[ReadLatency-1]);
      if (cmd_acc && (!in_range || (ddr_r_en_i && ddr_w_en_i))) begin
        err_q <= 1'b1;
      end
      // Stage 0 captures the word at the accepting edge; each stage only loads
      // when fed valid data, so the last stage holds r_data between returns.
      vld_q[0] <= rd_acc;
      if (rd_acc) begin
        dat_q[0] <= rd_word;
      end
      for (int i = 1; i < ReadLatency; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign ddr_r_valid_o = vld_q[ReadLatency-1];
  assign ddr_r_data_o  = dat_q[ReadLatency-1];
  assign error_o       = err_q;
  assign outstanding_o = cnt_q;

endmodule
